// File: rtl/wb_daq_dma_engine.sv
// N-channel DAQ write engine: round-robin arbitration of channel sample FIFOs
// into Wishbone incrementing bursts that fill per-channel circular buffers.
module wb_daq_dma_engine #(
  parameter int NUM_CH    = 4,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int LW        = 16,
  parameter int BURST_LEN = 4,
  parameter int MAX_RETRY = 7
) (
  input  logic                                            wb_clk,
  input  logic                                            wb_rst_n,
  input  logic                                            enable,
  input  logic [NUM_CH-1:0]                               ch_req,
  input  logic [NUM_CH*DW-1:0]                            ch_data,
  output logic [NUM_CH-1:0]                               ch_pop,
  input  logic [NUM_CH*AW-1:0]                            ch_base,
  input  logic [NUM_CH*LW-1:0]                            ch_len,
  input  logic [NUM_CH-1:0]                               ch_clear,
  output logic [NUM_CH-1:0]                               ch_wrap,
  output logic [NUM_CH-1:0]                               ch_err,
  output logic                                            busy,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grant_sel,
  output logic [AW-1:0]                                   wb_adr_o,
  output logic [DW-1:0]                                   wb_dat_o,
  output logic [DW/8-1:0]                                 wb_sel_o,
  output logic                                            wb_we_o,
  output logic                                            wb_cyc_o,
  output logic                                            wb_stb_o,
  output logic [2:0]                                      wb_cti_o,
  output logic [1:0]                                      wb_bte_o,
  input  logic                                            wb_ack_i,
  input  logic                                            wb_err_i,
  input  logic                                            wb_rty_i
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_RETRY} state_t;

  state_t            state;
  logic [GW-1:0]     rr_next;
  logic [BW-1:0]     beat;
  logic [RW-1:0]     retry_cnt;
  logic              cyc_q, stb_q;
  logic [LW-1:0]     ptr      [NUM_CH];
  logic [NUM_CH-1:0] clr_pend;

  logic [DW-1:0]     data_a   [NUM_CH];
  logic [AW-1:0]     base_a   [NUM_CH];
  logic [LW-1:0]     len_a    [NUM_CH];
  logic [NUM_CH-1:0] eligible, ch_active;
  logic              arb_found;
  logic [GW-1:0]     arb_idx;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    eligible  = '0;
    ch_active = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      data_a[k]    = ch_data[k*DW +: DW];
      base_a[k]    = ch_base[k*AW +: AW];
      len_a[k]     = ch_len[k*LW +: LW];
      eligible[k]  = ch_req[k] && (len_a[k] != '0);
      ch_active[k] = ((state == S_XFER) || (state == S_RETRY)) && (grant_sel == GW'(k));
    end
  end

  // Lowest eligible index at or above rr_next wins; otherwise wrap to the lowest.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(k);
      end
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[k] && (k >= int'(rr_next))) arb_idx = GW'(k);
    end
  end

  logic [LW-1:0] g_ptr, g_ptr_next;
  logic          g_at_end, last_beat, rty_exhausted;

  assign g_ptr         = ptr[grant_sel];
  assign g_at_end      = (g_ptr == len_a[grant_sel] - LW'(1));
  assign g_ptr_next    = g_at_end ? '0 : g_ptr + LW'(1);
  assign last_beat     = (beat == BW'(BURST_LEN - 1));
  assign rty_exhausted = (retry_cnt == RW'(MAX_RETRY - 1));

  assign busy     = (state != S_IDLE);
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = cyc_q;
  assign wb_sel_o = {(DW/8){cyc_q}};
  assign wb_bte_o = 2'b00;
  assign wb_adr_o = cyc_q ? base_a[grant_sel] + AW'({g_ptr, 2'b00}) : '0;
  assign wb_dat_o = cyc_q ? data_a[grant_sel] : '0;
  assign wb_cti_o = (!cyc_q || (BURST_LEN == 1)) ? 3'b000 :
                    last_beat                    ? 3'b111 : 3'b010;

  // err takes precedence over ack, so an err+ack beat is never popped.
  always_comb begin
    ch_pop = '0;
    if ((state == S_XFER) && stb_q && wb_ack_i && !wb_err_i) ch_pop[grant_sel] = 1'b1;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= S_IDLE;
      grant_sel <= '0;
      rr_next   <= '0;
      beat      <= '0;
      retry_cnt <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      ch_err    <= '0;
      ch_wrap   <= '0;
      clr_pend  <= '0;
      // NOTE: the pointer table is a few flops rather than a RAM, so it is reset.
      for (int k = 0; k < NUM_CH; k++) ptr[k] <= '0;
    end else begin
      ch_wrap <= '0;
      case (state)
        S_IDLE: if (enable && (|eligible)) state <= S_ARB;
        S_ARB: begin
          if (enable && arb_found) begin
            grant_sel <= arb_idx;
            rr_next   <= (arb_idx == GW'(NUM_CH - 1)) ? '0 : arb_idx + GW'(1);
            beat      <= '0;
            retry_cnt <= '0;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            state     <= S_XFER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_XFER: begin
          if (wb_err_i || (wb_rty_i && !wb_ack_i && rty_exhausted)) begin
            cyc_q             <= 1'b0;
            stb_q             <= 1'b0;
            ch_err[grant_sel] <= 1'b1;
            state             <= S_IDLE;
          end else if (wb_ack_i) begin
            retry_cnt      <= '0;
            ptr[grant_sel] <= g_ptr_next;
            if (g_at_end) ch_wrap[grant_sel] <= 1'b1;
            if (last_beat) begin
              cyc_q <= 1'b0;
              stb_q <= 1'b0;
              state <= S_IDLE;
            end else begin
              beat <= beat + BW'(1);
            end
          end else if (wb_rty_i) begin
            stb_q     <= 1'b0;
            retry_cnt <= retry_cnt + RW'(1);
            state     <= S_RETRY;
          end
        end
        S_RETRY: begin
          stb_q <= 1'b1;
          state <= S_XFER;
        end
        default: state <= S_IDLE;
      endcase

      // A clear aimed at the channel mid-burst waits until that burst is over.
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_active[k]) begin
          if (ch_clear[k]) clr_pend[k] <= 1'b1;
        end else if (ch_clear[k] || clr_pend[k]) begin
          ptr[k]      <= '0;
          ch_err[k]   <= 1'b0;
          clr_pend[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_daq_dma_engine.sv
// Scoreboard bench for wb_daq_dma_engine: planned beats are queued with their
// slave response; a monitor pops and compares each presented beat.
module tb_wb_daq_dma_engine;
  localparam int NUM_CH    = 4;
  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int LW        = 16;
  localparam int BL        = 4;
  localparam int MAX_RETRY = 7;

  typedef enum int {RSP_ACK, RSP_ERR, RSP_RTY} rsp_t;
  typedef struct {
    int             ch;
    logic [AW-1:0]  adr;
    logic [DW-1:0]  dat;
    logic [2:0]     cti;
    rsp_t           rsp;
  } beat_t;

  logic                 wb_clk = 1'b0;
  logic                 wb_rst_n;
  logic                 enable;
  logic [NUM_CH-1:0]    ch_req, ch_pop, ch_clear, ch_wrap, ch_err;
  logic [NUM_CH*DW-1:0] ch_data;
  logic [NUM_CH*AW-1:0] ch_base;
  logic [NUM_CH*LW-1:0] ch_len;
  logic                 busy;
  logic [1:0]           grant_sel;
  logic [AW-1:0]        wb_adr_o;
  logic [DW-1:0]        wb_dat_o;
  logic [DW/8-1:0]      wb_sel_o;
  logic                 wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]           wb_cti_o;
  logic [1:0]           wb_bte_o;
  logic                 wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  wb_daq_dma_engine #(
    .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .LW(LW), .BURST_LEN(BL), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .enable(enable),
    .ch_req(ch_req), .ch_data(ch_data), .ch_pop(ch_pop),
    .ch_base(ch_base), .ch_len(ch_len), .ch_clear(ch_clear),
    .ch_wrap(ch_wrap), .ch_err(ch_err), .busy(busy), .grant_sel(grant_sel),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk = ~wb_clk;

  int base_cfg [NUM_CH] = '{'h1000, 'h2000, 'h3000, 'h4000};
  int len_cfg  [NUM_CH] = '{16, 6, 16, 16};

  // Model state and observed counters.
  int exp_ptr [NUM_CH], exp_seq [NUM_CH], exp_pop [NUM_CH], exp_wrap [NUM_CH];
  logic [NUM_CH-1:0] exp_err;
  int seq [NUM_CH], pop_cnt [NUM_CH], wrap_cnt [NUM_CH];
  beat_t exp_q [$];
  int last_plan_n;
  int n_checks = 0, n_errors = 0;

  function automatic logic [DW-1:0] data_word(input int k, input int s);
    return {8'hA0 + 8'(k), 8'h5A, 16'(s)};
  endfunction

  // Sample FIFO heads: the head advances on each observed pop.
  always_comb
    for (int k = 0; k < NUM_CH; k++) ch_data[k*DW +: DW] = data_word(k, seq[k]);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Queue one burst for channel k; rty_n retries precede beat rty_beat, err ends at err_beat.
  task automatic plan_burst(input int k, input int err_beat, input int rty_beat, input int rty_n);
    beat_t b;
    last_plan_n = 0;
    for (int i = 0; i < BL; i++) begin
      b.ch  = k;
      b.adr = AW'(base_cfg[k] + exp_ptr[k] * 4);
      b.dat = data_word(k, exp_seq[k]);
      b.cti = (i == BL - 1) ? 3'b111 : 3'b010;
      if (i == rty_beat) begin
        for (int r = 0; r < rty_n; r++) begin
          b.rsp = RSP_RTY;
          exp_q.push_back(b);
          last_plan_n++;
          if (r == MAX_RETRY - 1) begin
            exp_err[k] = 1'b1;
            return;
          end
        end
      end
      if (i == err_beat) begin
        b.rsp = RSP_ERR;
        exp_q.push_back(b);
        last_plan_n++;
        exp_err[k] = 1'b1;
        return;
      end
      b.rsp = RSP_ACK;
      exp_q.push_back(b);
      last_plan_n++;
      exp_pop[k]++;
      exp_seq[k]++;
      if (exp_ptr[k] == len_cfg[k] - 1) begin
        exp_ptr[k] = 0;
        exp_wrap[k]++;
      end else begin
        exp_ptr[k]++;
      end
    end
  endtask

  task automatic check_counters(input string tag);
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("%s_pop%0d", tag, k), 64'(pop_cnt[k]), 64'(exp_pop[k]));
      check($sformatf("%s_wrap%0d", tag, k), 64'(wrap_cnt[k]), 64'(exp_wrap[k]));
      check($sformatf("%s_err%0d", tag, k), 64'(ch_err[k]), 64'(exp_err[k]));
    end
  endtask

  // Hold requests until the last planned burst starts, then wait for the queue to drain.
  task automatic run_bursts(input logic [NUM_CH-1:0] reqs, input string tag);
    int t = 0;
    ch_req = reqs;
    while (exp_q.size() >= last_plan_n && t < 300) begin
      @(negedge wb_clk);
      t++;
    end
    ch_req = '0;
    while ((exp_q.size() != 0 || busy) && t < 600) begin
      @(negedge wb_clk);
      t++;
    end
    check({tag, "_drained"}, 64'(t < 600), 64'(1));
    repeat (2) @(negedge wb_clk);
    #2;
    check_counters(tag);
  endtask

  task automatic clear_ch(input logic [NUM_CH-1:0] m);
    @(negedge wb_clk);
    ch_clear = m;
    @(negedge wb_clk);
    ch_clear = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (m[k]) begin
        exp_ptr[k] = 0;
        exp_err[k] = 1'b0;
      end
  endtask

  // Monitor and slave: compare each presented beat, answer with the planned response.
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge wb_clk);
      if (wb_cyc_o && wb_stb_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got adr %0h ch %0d, required no beat", wb_adr_o, grant_sel);
          wb_ack_i = 1'b1; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        end else begin
          b = exp_q.pop_front();
          check("grant", 64'(grant_sel), 64'(b.ch));
          check("adr", 64'(wb_adr_o), 64'(b.adr));
          check("dat", 64'(wb_dat_o), 64'(b.dat));
          check("cti", 64'(wb_cti_o), 64'(b.cti));
          check("we_sel_bte", 64'({wb_we_o, wb_sel_o, wb_bte_o}), 64'({1'b1, 4'hF, 2'b00}));
          wb_ack_i = (b.rsp == RSP_ACK);
          wb_err_i = (b.rsp == RSP_ERR);
          wb_rty_i = (b.rsp == RSP_RTY);
        end
      end else begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      end
      #1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_pop[k]) begin
          pop_cnt[k]++;
          seq[k]++;
        end
        if (ch_wrap[k]) wrap_cnt[k]++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int t;
    wb_rst_n = 1'b0;
    enable   = 1'b0;
    ch_req   = '0;
    ch_clear = '0;
    exp_err  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_base[k*AW +: AW] = AW'(base_cfg[k]);
      ch_len[k*LW +: LW]  = LW'(len_cfg[k]);
      exp_ptr[k] = 0; exp_seq[k] = 0; exp_pop[k] = 0; exp_wrap[k] = 0;
      seq[k] = 0; pop_cnt[k] = 0; wrap_cnt[k] = 0;
    end
    repeat (3) @(negedge wb_clk);
    check("rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pop_wrap_err", 64'({ch_pop, ch_wrap, ch_err}), 64'(0));
    check("rst_adr", 64'(wb_adr_o), 64'(0));
    check("rst_grant", 64'(grant_sel), 64'(0));
    wb_rst_n = 1'b1;
    enable   = 1'b1;

    // Round robin across all four channels from reset priority: 0,1,2,3,0.
    plan_burst(0, -1, -1, 0);
    plan_burst(1, -1, -1, 0);
    plan_burst(2, -1, -1, 0);
    plan_burst(3, -1, -1, 0);
    plan_burst(0, -1, -1, 0);
    run_bursts(4'hF, "rr");

    // Single ch0 burst from pointer 0: 1000..100C.
    clear_ch(4'hF);
    plan_burst(0, -1, -1, 0);
    run_bursts(4'h1, "ch0");

    // ch1 length 6: second burst straddles the wrap.
    plan_burst(1, -1, -1, 0);
    plan_burst(1, -1, -1, 0);
    run_bursts(4'h2, "wrap");

    // err on the second beat of ch2, then clear and restart at the base.
    plan_burst(2, 1, -1, 0);
    run_bursts(4'h4, "err");
    clear_ch(4'h4);
    #2;
    check("err_cleared", 64'(ch_err[2]), 64'(0));
    plan_burst(2, -1, -1, 0);
    run_bursts(4'h4, "after_clr");

    // Three retries then ack; then MAX_RETRY retries escalate to err.
    plan_burst(3, -1, 0, 3);
    run_bursts(4'h8, "rty3");
    plan_burst(3, -1, 2, MAX_RETRY);
    run_bursts(4'h8, "rty_max");

    // enable drops mid-burst: burst finishes, no new grant despite held request.
    plan_burst(0, -1, -1, 0);
    ch_req = 4'h1;
    t = 0;
    while (exp_q.size() >= BL && t < 100) begin
      @(negedge wb_clk);
      t++;
    end
    enable = 1'b0;
    repeat (12) @(negedge wb_clk);
    #2;
    check("en_low_busy", 64'(busy), 64'(0));
    check("en_low_drained", 64'(exp_q.size()), 64'(0));
    check("en_low_pop0", 64'(pop_cnt[0]), 64'(exp_pop[0]));
    ch_req = '0;
    enable = 1'b1;

    // Reset mid-burst, then ch0 restarts at pointer 0.
    plan_burst(0, -1, -1, 0);
    ch_req = 4'h1;
    t = 0;
    while (exp_q.size() > 2 && t < 100) begin
      @(negedge wb_clk);
      t++;
    end
    #3;
    check("rst_mid_active", 64'(wb_cyc_o), 64'(1));
    wb_rst_n = 1'b0;
    ch_req   = '0;
    #1;
    check("rst_mid_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
    check("rst_mid_pop", 64'(ch_pop), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    exp_q.delete();
    exp_err = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_ptr[k] = 0; exp_seq[k] = 0; exp_pop[k] = 0; exp_wrap[k] = 0;
      seq[k] = 0; pop_cnt[k] = 0; wrap_cnt[k] = 0;
    end
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    plan_burst(0, -1, -1, 0);
    run_bursts(4'h1, "restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
